// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 16-bit asynchronous SRAM controller: state encoding,
// SRAM bus widths and the data-memory base address used by the optional address offset.
package sram_controller_pkg;

  localparam int          SRAM_ADDR_W   = 18;
  localparam int          SRAM_DATA_W   = 16;
  localparam logic [31:0] DATA_MEM_BASE = 32'd1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses and stalls the pipeline meanwhile.
// Optional: define SRAM_ADDR_OFFSET_EN to subtract DATA_MEM_BASE before forming the SRAM address.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memReadEn,
  input  logic                   memWriteEn,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output state_t                 o_dbg_state
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_write;
  logic [SRAM_DATA_W-1:0] r_wdata_hi;
  logic [SRAM_DATA_W-1:0] r_rd_lo;
  logic [31:0]            r_rdata;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [SRAM_DATA_W-1:0] r_dq_out;
  logic                   r_dq_oe;
  logic                   r_we_n;
  logic                   r_oe_n;
  logic                   r_ce_n;

  logic                   w_req;
  logic                   w_last;
  logic [18:0]            w_in_map;
  logic                   w_unused_bits;

  assign w_req  = memReadEn | memWriteEn;
  assign w_last = (r_cnt == LAST_CNT);

  // Only address bits [18:0] reach the word address, so a 19-bit subtract is exact.
`ifdef SRAM_ADDR_OFFSET_EN
  assign w_in_map = address[18:0] - DATA_MEM_BASE[18:0];
`else
  assign w_in_map = address[18:0];
`endif
  assign w_unused_bits = ^{address[31:19], w_in_map[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_wdata_hi  <= '0;
      r_rd_lo     <= '0;
      r_rdata     <= 32'd0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_ce_n      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            // A simultaneous read and write request is served as a write.
            r_state     <= ACC_LO;
            r_cnt       <= 4'd0;
            r_write     <= memWriteEn;
            r_wdata_hi  <= writeData[31:16];
            r_sram_addr <= {w_in_map[18:2], 1'b0};
            r_dq_out    <= writeData[15:0];
            r_dq_oe     <= memWriteEn;
            r_we_n      <= ~memWriteEn;
            r_oe_n      <= memWriteEn;
            r_ce_n      <= 1'b0;
          end
        end
        ACC_LO: begin
          if (w_last) begin
            r_state        <= ACC_HI;
            r_cnt          <= 4'd0;
            r_sram_addr[0] <= 1'b1;
            r_dq_out       <= r_wdata_hi;
            if (!r_write) r_rd_lo <= SRAM_DQ;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ACC_HI: begin
          if (w_last) begin
            r_state <= DONE;
            r_cnt   <= 4'd0;
            r_dq_oe <= 1'b0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ce_n  <= 1'b1;
            if (!r_write) r_rdata <= {SRAM_DQ, r_rd_lo};
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready       = ~w_req | (r_state == DONE);
  assign readData    = r_rdata;
  assign SRAM_ADDR   = r_sram_addr;
  assign SRAM_DQ     = r_dq_oe ? r_dq_out : {SRAM_DATA_W{1'bz}};
  assign SRAM_WE_N   = r_we_n;
  assign SRAM_OE_N   = r_oe_n;
  assign SRAM_CE_N   = r_ce_n;
  assign SRAM_UB_N   = r_ce_n;
  assign SRAM_LB_N   = r_ce_n;
  assign o_dbg_state = r_state;

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, cycles each 16-bit half-access is held (legal 1..15).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 memReadEn  input  1  load request from the EXE/MEM pipeline register.
REQ-005 memWriteEn  input  1  store request from the EXE/MEM pipeline register.
REQ-006 address  input  32  byte address (ALU result).
REQ-007 writeData  input  32  store value.
REQ-008 readData  output  32  assembled load word.
REQ-009 ready  output  1  high = no access pending; drives pipeline-register enable/freeze.
REQ-010 SRAM_DQ  inout  16  SRAM data bus.
REQ-011 SRAM_ADDR  output  18  SRAM halfword address.
REQ-012 SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  SRAM strobes, active-low.

Function
REQ-013 States: IDLE, ACC_LO, ACC_HI, DONE; 4-bit wait counter.
REQ-014 IDLE with memReadEn|memWriteEn: latch address, writeData and op; next state ACC_LO, counter cleared.
REQ-015 ACC_LO/ACC_HI each last exactly WAIT_CYCLES cycles; then ACC_LO->ACC_HI, ACC_HI->DONE.
REQ-016 DONE lasts one cycle, then IDLE unconditionally.
REQ-017 ready = !(memReadEn|memWriteEn) | (state==DONE), combinational; request cycle already sees ready=0.
REQ-018 Latency, WAIT_CYCLES=1: request in cycle 0, ready low cycles 0-2, high cycle 3; generally 2*WAIT_CYCLES+1 stall cycles.
REQ-019 SRAM_ADDR: ACC_LO = {wordAddr,1'b0}, ACC_HI = {wordAddr,1'b1}; wordAddr = latched address[18:2] after REQ-028 mapping.
REQ-020 SRAM_CE_N, SRAM_UB_N, SRAM_LB_N low in ACC_LO/ACC_HI, high otherwise.
REQ-021 Write: SRAM_WE_N low and SRAM_DQ driven with writeData[15:0] in ACC_LO, [31:16] in ACC_HI; SRAM_OE_N high.
REQ-022 Read: SRAM_OE_N low, SRAM_DQ high-Z; low half captured at last ACC_LO cycle, high half at last ACC_HI cycle.
REQ-023 readData valid from DONE; held until the next read overwrites it; writes never change it.
REQ-024 SRAM_DQ high-Z in all states except write ACC_LO/ACC_HI.
REQ-025 memReadEn and memWriteEn both high: treated as write.
REQ-026 Request inputs ignored outside IDLE; latched copies used, so input changes mid-access have no effect.

Reset
REQ-027 rst high at a rising edge: state IDLE, counter 0, readData 0, latched address/data/op 0; from next cycle all SRAM strobes high, SRAM_DQ high-Z, ready follows REQ-017. Mid-access reset aborts; no partial-word completion.

Configuration
REQ-028 SRAM_ADDR_OFFSET_EN defined: wordAddr derived from (address - 32'd1024); undefined: from address directly.

Structure
REQ-029 Shared package holds state encoding, SRAM_ADDR_W=18, SRAM_DATA_W=16, DATA_MEM_BASE=1024.
REQ-030 No sub-module; FSM, counter and tristate in sram_controller.

Verification
REQ-031 Write 0xDEADBEEF to 1028 with offset enabled, W=1: ready low 3 cycles; SRAM_ADDR 2 then 3, DQ 0xBEEF then 0xDEAD, WE_N low 2 cycles.
REQ-032 Read 1028 from model holding 0xBEEF/0xDEAD: readData=0xDEADBEEF in DONE; ready high exactly that cycle.
REQ-033 WAIT_CYCLES=3: ready low 7 cycles per access; each SRAM_ADDR value stable 3 cycles.
REQ-034 Back-to-back read then write: second request accepted in the cycle after DONE; no idle cycle lost.
REQ-035 rst asserted in ACC_HI of a write: next cycle IDLE, WE_N high, DQ high-Z, readData 0.
REQ-036 Read and write both high with writeData 0x12345678: write performed, DQ 0x5678 then 0x1234, readData unchanged.
